// File: rtl/ifq_pkg.sv
// Shared widths and the line word-select helper for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned LINE_W         = 128;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;

  // Word 0 is the lowest address and sits in the most significant slot of the line.
  function automatic logic [INST_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        k);
    return line[LINE_W-1-INST_W*k -: INST_W];
  endfunction

endpackage

// File: rtl/ifq_line_ram.sv
// Line storage: one synchronous write port, one asynchronous read port, no data reset.
module ifq_line_ram
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: line-aligned I-cache fetch, circular line buffer, per-word dispatch.
module ifq
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       cache_pc_out,
  output logic              cache_rd_en,
  input  logic [LINE_W-1:0] cache_dout,
  input  logic              cache_dout_valid,
  input  logic              jmp_branch_valid,
  input  logic [31:0]       jmp_branch_address,
  input  logic              ifq_rd_en,
  output logic [31:0]       ifq_inst,
  output logic [31:0]       ifq_pc,
  output logic [31:0]       ifq_pc_plus4,
  output logic              ifq_empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [27:0]       fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [1:0]        rofs_q, rofs_d;
  logic [29:0]       dpc_q, dpc_d;
  logic              push, pop, release_line;
  logic [LINE_W-1:0] head_line;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^jmp_branch_address[1:0];

  assign cache_rd_en  = reset && (count_q != FullCnt);
  assign cache_pc_out = {fetch_pc_q, 4'b0000};
  assign push         = cache_rd_en && cache_dout_valid && !jmp_branch_valid;
  assign ifq_empty    = (count_q == '0);
  assign pop          = ifq_rd_en && !ifq_empty;
  assign release_line = pop && (rofs_q == 2'd3);

  ifq_line_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (cache_dout),
    .raddr (rptr_q),
    .rdata (head_line)
  );

  assign ifq_inst     = ifq_empty ? 32'h0 : word_sel(head_line, rofs_q);
  assign ifq_pc       = {dpc_q, 2'b00};
  assign ifq_pc_plus4 = ifq_pc + 32'd4;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rofs_d     = rofs_q;
    dpc_d      = dpc_q;
    if (!reset) begin
      fetch_pc_d = RESET_PC[31:4];
      dpc_d      = RESET_PC[31:2];
      rofs_d     = RESET_PC[3:2];
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else if (jmp_branch_valid) begin
      // The first line after a redirect is entered at the target's word offset.
      fetch_pc_d = jmp_branch_address[31:4];
      dpc_d      = jmp_branch_address[31:2];
      rofs_d     = jmp_branch_address[3:2];
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wptr_d     = wptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 28'd1;
      end
      if (pop) begin
        dpc_d  = dpc_q + 30'd1;
        rofs_d = rofs_q + 2'd1;
        if (release_line) rptr_d = rptr_q + AW'(1);
      end
      unique case ({push, release_line})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    wptr_q     <= wptr_d;
    rptr_q     <= rptr_d;
    count_q    <= count_d;
    rofs_q     <= rofs_d;
    dpc_q      <= dpc_d;
  end

endmodule

// File: doc/ifq.md
# ifq

Instruction fetch queue between the instruction cache and dispatch. It generates line-aligned fetch addresses and requests 128-bit lines from the I-cache. Returned lines are buffered in a small circular queue. Dispatch pops one 32-bit instruction per cycle together with its PC. A resolved jump or branch flushes the queue and redirects fetch.

## Interface
- DEPTH, 4: queue capacity in 128-bit lines; power of two, ≥2
- RESET_PC, 32'h0000_0000: fetch and dispatch PC after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- cache_pc_out  out  32  line-aligned fetch address to I-cache; bits [3:0] always 0
- cache_rd_en  out  1  I-cache read request
- cache_dout  in  128  returned line; [127:96] = word 0 (lowest address) … [31:0] = word 3
- cache_dout_valid  in  1  cache_dout valid in the same cycle as cache_rd_en
- jmp_branch_valid  in  1  redirect request (one-cycle pulse)
- jmp_branch_address  in  32  redirect target; bits [1:0] ignored
- ifq_rd_en  in  1  dispatch pops the head instruction
- ifq_inst  out  32  head instruction; 32'h0 when empty
- ifq_pc  out  32  PC of ifq_inst
- ifq_pc_plus4  out  32  ifq_pc + 4, modulo 2^32
- ifq_empty  out  1  no instruction available

## Operation
- State:
  - fetch_pc[31:4]
  - line storage [DEPTH]
  - wptr, rptr, each log2(DEPTH) bits, wrapping
  - count, log2(DEPTH)+1 bits
  - rofs[1:0]: word offset within the head line
  - dpc[31:2]
- Reset (reset==0 at an edge):
  - fetch_pc = RESET_PC[31:4]; dpc = RESET_PC[31:2]; rofs = RESET_PC[3:2]
  - count, wptr and rptr are cleared to 0.
  - While reset is low, cache_rd_en = 0.
  - After reset:
    - ifq_empty = 1, ifq_inst = 0
    - ifq_pc = RESET_PC, ifq_pc_plus4 = RESET_PC+4
    - cache_pc_out = {RESET_PC[31:4],4'b0}
- Fetch:
  - cache_rd_en = reset && (count != DEPTH).
  - A push occurs when cache_rd_en && cache_dout_valid && !jmp_branch_valid.
  - On a push: the line is written at wptr, wptr++, and fetch_pc++ (wraps at 2^28).
- Pop:
  - ifq_inst = word rofs of line rptr, combinational (first-word fall-through).
  - A pop occurs when ifq_rd_en && !ifq_empty. ifq_rd_en while empty is ignored, with no state change.
  - On a pop: dpc++ and rofs++.
  - If rofs was 3: rptr++ and the line is released (count decrements).
- Count update: push only → +1; release only → −1; push and release together → unchanged.
- Full: count==DEPTH deasserts cache_rd_en. A release in the same cycle does not allow a push in that cycle.
- Redirect (jmp_branch_valid=1) overrides any push or pop in that cycle:
  - count, wptr and rptr are cleared to 0.
  - fetch_pc = target[31:4]; dpc = target[31:2]; rofs = target[3:2]
  - The first line fetched after a redirect is consumed starting at word rofs. Later lines start at word 0.
- Priority: reset > redirect > push/pop.

## Timing
- I-cache path is combinational. A line pushed at edge N drives ifq_inst and clears ifq_empty from cycle N+1.
- Redirect at edge N:
  - cache_pc_out shows the target line in cycle N+1.
  - The target instruction is on ifq_inst in cycle N+2, provided the cache returns valid.
- Steady-state throughput is one instruction per cycle with pops every cycle. One line lasts 4 pops, so the queue does not starve while DEPTH ≥ 2.
- ifq_pc and ifq_pc_plus4 are registered-derived; no combinational path from ifq_rd_en to any output.
- A combinational path exists from reset and count to cache_rd_en only.

## Structure
- Shared package constants:
  - LINE_W=128, INST_W=32, WORDS_PER_LINE=4
  - word-select helper: word k = line[LINE_W-1-32k -: 32]
- Sub-module ifq_line_ram: DEPTH×128 register file with one synchronous write port and one asynchronous read port, no reset on data.
- Pointers, count and PC logic stay in ifq.

## Test plan
- **Reset, then fill:** RESET_PC=0, cache always valid, no pops.
  - Addresses 0x00, 0x10, 0x20 and 0x30 are requested.
  - cache_rd_en drops after 4 pushes; count==4.
  - ifq_inst = word 0 of line 0, ifq_pc=0.
- **Streaming:** pop every cycle after the first push.
  - ifq_pc sequence is 0, 4, 8, … 0x3C with no bubbles.
  - ifq_inst matches preloaded words in order.
- **Unaligned redirect:** jmp_branch_valid with target 0x0000_0148 mid-stream.
  - Next cycle cache_pc_out=0x140, ifq_empty=1.
  - Two cycles later ifq_pc=0x148 with word 2 of that line; next pop gives 0x14C, then 0x150.
- **Redirect with push and pop in the same cycle:**
  - The redirect wins: no push, and count=0 afterwards.
  - The popped instruction is not re-presented.
- **Pop when empty and full boundary:**
  - ifq_rd_en held high while empty → no change; ifq_inst stays 0.
  - At count==4, releasing the last word of the head line with no push → count=3; cache_rd_en reasserts the next cycle.
- **Reset mid-stream:** reset low with count=3 → next cycle ifq_empty=1 and cache_pc_out={RESET_PC[31:4],4'b0}.
